// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the register-file writeback arbiter:
//   DATA_W_DEF / ADDR_W_DEF : default RF data / address widths
//   X0_ADDR                 : architectural zero register (never written)
//   gnt_e                   : grant decision (GNT_NONE, GNT_ALU, GNT_LSU)
// -----------------------------------------------------------------------------
package rf_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   localparam logic [ADDR_W_DEF-1:0] X0_ADDR = '0;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_ALU  = 2'd1,
      GNT_LSU  = 2'd2
   } gnt_e;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter_if
// Bundles the two writeback request channels and the registered RF write port.
//   ALU channel : alu_valid, alu_rdAddr, alu_rd  -> alu_ready
//   LSU channel : lsu_valid, lsu_rdAddr, lsu_rd  -> lsu_ready
//   RF port     : rf_we, rf_rdAddr, rf_rd, wb_conflict
// Modports:
//   slave  : the arbiter (consumes requests, drives readys and RF port)
//   master : the requesters / environment (drives requests, observes the rest)
// Handshake: a request transfers in any cycle where valid && ready is high.
//   ready is combinational from valid and never high without valid; a
//   requester that sees ready=0 keeps valid and its payload stable until it
//   is accepted, because rejected requests are not buffered.
// -----------------------------------------------------------------------------
interface rf_wb_arbiter_if
   import rf_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);
   logic              alu_valid;
   logic [ADDR_W-1:0] alu_rdAddr;
   logic [DATA_W-1:0] alu_rd;
   logic              alu_ready;

   logic              lsu_valid;
   logic [ADDR_W-1:0] lsu_rdAddr;
   logic [DATA_W-1:0] lsu_rd;
   logic              lsu_ready;

   logic              rf_we;
   logic [ADDR_W-1:0] rf_rdAddr;
   logic [DATA_W-1:0] rf_rd;
   logic              wb_conflict;

   modport slave (
      input  alu_valid, alu_rdAddr, alu_rd,
      input  lsu_valid, lsu_rdAddr, lsu_rd,
      output alu_ready, lsu_ready,
      output rf_we, rf_rdAddr, rf_rd, wb_conflict
   );

   modport master (
      output alu_valid, alu_rdAddr, alu_rd,
      output lsu_valid, lsu_rdAddr, lsu_rd,
      input  alu_ready, lsu_ready,
      input  rf_we, rf_rdAddr, rf_rd, wb_conflict
   );
endinterface

// File: rtl/rf_wb_arb_core.sv
// -----------------------------------------------------------------------------
// rf_wb_arb_core
// Combinational grant between ALU and LSU plus the arbitration state.
// Build option RF_WB_RR_EN:
//   defined   : round-robin; on a tie the requester not granted last wins.
//               A last-grant flag (reset to LSU) updates on every transfer.
//   undefined : fixed LSU priority with a 2-bit ALU wait counter; once the
//               ALU has waited STARVE_MAX cycles it wins the next tie.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   alu_valid, lsu_valid : request valids
//   gnt                  : grant for this cycle (GNT_NONE while rst=1)
// -----------------------------------------------------------------------------
module rf_wb_arb_core
   import rf_pkg::*;
#(
   parameter int STARVE_MAX = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic alu_valid,
   input  logic lsu_valid,
   output gnt_e gnt
);

`ifdef RF_WB_RR_EN
   gnt_e last_gnt_q, last_gnt_d;

   always_comb begin
      gnt = GNT_NONE;
      if (!rst) begin
         if (alu_valid && lsu_valid)
            gnt = (last_gnt_q == GNT_ALU) ? GNT_LSU : GNT_ALU;
         else if (alu_valid)
            gnt = GNT_ALU;
         else if (lsu_valid)
            gnt = GNT_LSU;
      end
   end

   always_comb begin
      last_gnt_d = last_gnt_q;
      if (gnt != GNT_NONE)
         last_gnt_d = gnt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_gnt_q <= GNT_LSU;
      else     last_gnt_q <= last_gnt_d;
   end
`else
   localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);

   logic [1:0] wait_q, wait_d;

   always_comb begin
      gnt = GNT_NONE;
      if (!rst) begin
         if (alu_valid && lsu_valid)
            gnt = (wait_q == STARVE_LIM) ? GNT_ALU : GNT_LSU;
         else if (alu_valid)
            gnt = GNT_ALU;
         else if (lsu_valid)
            gnt = GNT_LSU;
      end
   end

   // Counts cycles the ALU sits valid but unserved; saturates so a
   // STARVE_MAX of 3 cannot wrap back to 0 and lose the forced grant.
   always_comb begin
      wait_d = wait_q;
      if (!alu_valid || gnt == GNT_ALU)
         wait_d = 2'd0;
      else if (wait_q != 2'd3)
         wait_d = wait_q + 2'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) wait_q <= 2'd0;
      else     wait_q <= wait_d;
   end
`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
// Shares one register-file write port between the ALU and the LSU.
// A transfer in cycle N shows up on the registered RF port in cycle N+1 for
// exactly one cycle. Writes to x0 are accepted but never raise rf_we.
// Build option RF_WB_RR_EN selects round-robin instead of fixed LSU priority.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset (also masks both readys)
//   bus  : rf_wb_arbiter_if.slave (request channels + RF write port)
// -----------------------------------------------------------------------------
module rf_wb_arbiter
   import rf_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int STARVE_MAX = 3
) (
   input logic            clk,
   input logic            rst,
   rf_wb_arbiter_if.slave bus
);

   gnt_e gnt;

   logic              rf_we_q,       rf_we_d;
   logic [ADDR_W-1:0] rf_rd_addr_q,  rf_rd_addr_d;
   logic [DATA_W-1:0] rf_rd_q,       rf_rd_d;
   logic              wb_conflict_q, wb_conflict_d;

   rf_wb_arb_core #(
      .STARVE_MAX (STARVE_MAX)
   ) u_core (
      .clk       (clk),
      .rst       (rst),
      .alu_valid (bus.alu_valid),
      .lsu_valid (bus.lsu_valid),
      .gnt       (gnt)
   );

   assign bus.alu_ready = (gnt == GNT_ALU);
   assign bus.lsu_ready = (gnt == GNT_LSU);

   // Address/data follow every accepted request, including x0 targets;
   // only the write enable is suppressed for x0.
   always_comb begin
      rf_we_d       = 1'b0;
      rf_rd_addr_d  = rf_rd_addr_q;
      rf_rd_d       = rf_rd_q;
      wb_conflict_d = bus.alu_valid && bus.lsu_valid;
      if (gnt == GNT_ALU) begin
         rf_we_d      = (bus.alu_rdAddr != ADDR_W'(X0_ADDR));
         rf_rd_addr_d = bus.alu_rdAddr;
         rf_rd_d      = bus.alu_rd;
      end else if (gnt == GNT_LSU) begin
         rf_we_d      = (bus.lsu_rdAddr != ADDR_W'(X0_ADDR));
         rf_rd_addr_d = bus.lsu_rdAddr;
         rf_rd_d      = bus.lsu_rd;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we_q       <= 1'b0;
         rf_rd_addr_q  <= '0;
         rf_rd_q       <= '0;
         wb_conflict_q <= 1'b0;
      end else begin
         rf_we_q       <= rf_we_d;
         rf_rd_addr_q  <= rf_rd_addr_d;
         rf_rd_q       <= rf_rd_d;
         wb_conflict_q <= wb_conflict_d;
      end
   end

   assign bus.rf_we       = rf_we_q;
   assign bus.rf_rdAddr   = rf_rd_addr_q;
   assign bus.rf_rd       = rf_rd_q;
   assign bus.wb_conflict = wb_conflict_q;

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, RF write data width.
REQ-002 Parameter ADDR_W, default 5, RF register address width.
REQ-003 Parameter STARVE_MAX, default 3, maximum consecutive cycles the ALU may wait while the LSU is granted (fixed-priority mode only).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 alu_valid  input  1  ALU writeback request.
REQ-007 alu_rdAddr  input  ADDR_W  ALU destination register.
REQ-008 alu_rd  input  DATA_W  ALU result.
REQ-009 alu_ready  output  1  ALU request accepted this cycle.
REQ-010 lsu_valid  input  1  load writeback request.
REQ-011 lsu_rdAddr  input  ADDR_W  load destination register.
REQ-012 lsu_rd  input  DATA_W  load data.
REQ-013 lsu_ready  output  1  LSU request accepted this cycle.
REQ-014 rf_we  output  1  RF write enable (LoadRF), registered.
REQ-015 rf_rdAddr  output  ADDR_W  RF write address, registered.
REQ-016 rf_rd  output  DATA_W  RF write data, registered.
REQ-017 wb_conflict  output  1  registered pulse: both requesters were valid in the previous cycle.

Function
REQ-018 The block SHALL share one RF write port between ALU and LSU; a transfer occurs when valid && ready.
REQ-019 alu_ready/lsu_ready SHALL be combinational from the valids and arbitration state; at most one SHALL be high per cycle, and never without its valid.
REQ-020 A lone valid requester SHALL be granted the same cycle.
REQ-021 A transfer in cycle N SHALL drive rf_we=1, rf_rdAddr and rf_rd with the granted request in cycle N+1 for exactly one cycle (latency 1).
REQ-022 A transfer with rdAddr==0 SHALL be accepted (ready=1) but SHALL produce rf_we=0 in N+1; x0 is never written.
REQ-023 Without a transfer in cycle N, rf_we SHALL be 0 in N+1; rf_rdAddr/rf_rd SHALL hold their last values.
REQ-024 When both requesters are valid, the loser SHALL see ready=0 and must hold its request stable; the block SHALL NOT buffer rejected requests.
REQ-025 Both requesters targeting the same rdAddr SHALL be serialized in grant order; the later grant's data SHALL be the final RF value.
REQ-026 Fixed-priority mode: LSU wins ties; a 2-bit wait counter SHALL increment each cycle the ALU is valid and not granted, and SHALL clear on an ALU grant or when alu_valid=0.
REQ-027 Fixed-priority mode: when the wait counter equals STARVE_MAX and both are valid, the ALU SHALL be granted.

Reset
REQ-028 While rst=1: rf_we=0, rf_rdAddr=0, rf_rd=0, wb_conflict=0, wait counter=0, last-grant flag=LSU.
REQ-029 While rst=1, alu_ready=0 and lsu_ready=0; a request present during reset SHALL NOT be transferred.
REQ-030 Reset asserted mid-operation SHALL cancel a pending rf_we pulse immediately (asynchronously).

Configuration
REQ-031 Macro RF_WB_RR_EN defined: round-robin arbitration; on a tie, the requester not granted last SHALL win; the last-grant flag updates on every transfer; the wait counter is absent.
REQ-032 Macro RF_WB_RR_EN undefined: fixed LSU priority with the starvation limit of REQ-026/027.

Structure
REQ-033 Shared package rf_pkg SHALL hold the DATA_W/ADDR_W defaults, the x0 address constant, and the grant enum (GNT_NONE, GNT_ALU, GNT_LSU).
REQ-034 The grant decision SHALL be a sub-module rf_wb_arb_core (combinational grant + last-grant/wait-counter state); the top registers the RF outputs.

Verification
REQ-035 ALU only, rdAddr=5'h10, rd=32'hA -> alu_ready=1 same cycle; next cycle rf_we=1, rf_rdAddr=5'h10, rf_rd=32'hA; the following cycle rf_we=0.
REQ-036 ALU (5'h3, 32'h1) and LSU (5'h4, 32'h2) valid together, fixed mode -> LSU granted first, wb_conflict=1 in the next cycle; ALU granted the next cycle; RF writes 4 then 3.
REQ-037 Fixed mode, LSU valid continuously and ALU valid -> ALU granted on its 4th waiting cycle (STARVE_MAX=3); counter clears.
REQ-038 RR mode, both valid for 4 cycles -> grants alternate: ALU, LSU, ALU, LSU.
REQ-039 LSU writes rdAddr=0, rd=32'hFFFF_FFFF -> lsu_ready=1; rf_we stays 0.
REQ-040 Assert rst in the cycle after a grant -> rf_we drops to 0 without waiting for a clock edge; both ready outputs are 0 during reset.
